// File: rtl/noc_local_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_local_ingress: router-side NI flit link endpoint. It buffers flits,    |
// | checks the header and wormhole-locks each packet onto one of 4 ports.     |
// | Optional macro: NOC_INGRESS_BAD_HDR_DROP_EN (drop bad-header packets).    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module noc_local_ingress #(
  parameter int         DEPTH      = 8,
  parameter logic [5:0] HDR_PREFIX = 6'b101111,
  parameter logic [7:0] TAIL_FLIT  = 8'hFF,
  parameter int         MAX_DATA   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] flit_in,
  input  logic       flit_in_valid,
  output logic       noc_ready,
  output logic [7:0] out_flit,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic       err_hdr,
  output logic       err_len,
  output logic       pkt_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_DATA + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [1:0]    dest_q, dest_d;
  logic [DW-1:0] data_cnt_q, data_cnt_d;
  logic          hdr_seen_q, hdr_seen_d;
  logic          err_hdr_q, err_hdr_d;
  logic          err_len_q, err_len_d;
  logic          pkt_done_q, pkt_done_d;

  logic          empty, full, push, pop;
  logic [7:0]    head;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    head      = mem_q[rd_ptr_q];
    push      = flit_in_valid && !full;
    noc_ready = !full;
    out_flit  = empty ? 8'h00 : head;
    out_valid = (state_q == ST_FWD && !empty) ? (4'b0001 << dest_q) : 4'b0000;
  end

  // Packet control: the header is inspected in IDLE but only popped as the
  // first flit of FWD/DROP, so the downstream port always sees it.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    data_cnt_d = data_cnt_q;
    hdr_seen_d = hdr_seen_q;
    err_hdr_d  = 1'b0;
    err_len_d  = 1'b0;
    pkt_done_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          dest_d     = head[1:0];
          data_cnt_d = '0;
          hdr_seen_d = 1'b0;
          if (head[7:2] == HDR_PREFIX) begin
            state_d = ST_FWD;
          end else begin
            err_hdr_d = 1'b1;
`ifdef NOC_INGRESS_BAD_HDR_DROP_EN
            state_d = ST_DROP;
`else
            state_d = ST_FWD;
`endif
          end
        end
      end
      ST_FWD, ST_DROP: begin
        pop = !empty && ((state_q == ST_DROP) || out_ready[dest_q]);
        if (pop) begin
          if (!hdr_seen_q) begin
            hdr_seen_d = 1'b1;
          end else if (head == TAIL_FLIT && data_cnt_q != '0) begin
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (data_cnt_q == DW'(MAX_DATA)) begin
            err_len_d  = 1'b1;
            pkt_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            data_cnt_d = data_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= flit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      dest_q     <= 2'd0;
      data_cnt_q <= '0;
      hdr_seen_q <= 1'b0;
      err_hdr_q  <= 1'b0;
      err_len_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      dest_q     <= dest_d;
      data_cnt_q <= data_cnt_d;
      hdr_seen_q <= hdr_seen_d;
      err_hdr_q  <= err_hdr_d;
      err_len_q  <= err_len_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign err_hdr  = err_hdr_q;
  assign err_len  = err_len_q;
  assign pkt_done = pkt_done_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_local_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for noc_local_ingress: packet-level model feeds an expected
// queue, an independent monitor checks every forwarded flit and pulse.
module tb_noc_local_ingress;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       noc_ready;
  logic [7:0] out_flit;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       err_hdr, err_len, pkt_done;

  noc_local_ingress dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flit_in       (flit_in),
    .flit_in_valid (flit_in_valid),
    .noc_ready     (noc_ready),
    .out_flit      (out_flit),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_hdr       (err_hdr),
    .err_len       (err_len),
    .pkt_done      (pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] port;
    logic [7:0] flit;
    bit         done;
    bit         elen;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int exp_hdr = 0, exp_elen = 0, exp_done = 0;
  int obs_hdr = 0, obs_elen = 0, obs_done = 0;

  // reference model: packet parser state
  bit         m_in   = 1'b0;
  bit         m_drop = 1'b0;
  int         m_cnt  = 0;
  logic [1:0] m_port = 2'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void add_exp(logic [7:0] f, bit d, bit e);
    exp_t x;
    x.port = m_port; x.flit = f; x.done = d; x.elen = e;
    if (!m_drop) exp_q.push_back(x);
  endfunction

  function automatic void model_push(logic [7:0] f);
    if (!m_in) begin
      m_in = 1'b1; m_cnt = 0; m_port = f[1:0]; m_drop = 1'b0;
      if (f[7:2] != 6'b101111) begin
        exp_hdr++;
`ifdef NOC_INGRESS_BAD_HDR_DROP_EN
        m_drop = 1'b1;
`endif
      end
      add_exp(f, 1'b0, 1'b0);
    end else if (f == 8'hFF && m_cnt >= 1) begin
      exp_done++; add_exp(f, 1'b1, 1'b0); m_in = 1'b0;
    end else if (m_cnt == 4) begin
      exp_done++; exp_elen++; add_exp(f, 1'b1, 1'b1); m_in = 1'b0;
    end else begin
      m_cnt++; add_exp(f, 1'b0, 1'b0);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_in = 1'b0; m_drop = 1'b0; m_cnt = 0;
  endfunction

  // monitor: samples 2ns after the falling edge, inputs are stable there
  bit pend = 1'b0, pend_done = 1'b0, pend_elen = 1'b0;
  always begin
    @(negedge clk); #2;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("pkt_done", 32'(pkt_done), 32'(pend_done));
        chk("err_len", 32'(err_len), 32'(pend_elen));
        pend = 1'b0;
      end
      if (err_hdr)  obs_hdr++;
      if (err_len)  obs_elen++;
      if (pkt_done) obs_done++;
      if (out_valid != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'(0));
        end else begin
          chk("port", 32'(out_valid), 32'(1) << exp_q[0].port);
          chk("flit", 32'(out_flit), 32'(exp_q[0].flit));
          if ((out_valid & out_ready) != 4'b0000) begin
            pend      = 1'b1;
            pend_done = exp_q[0].done;
            pend_elen = exp_q[0].elen;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] f);
    int t = 0;
    flit_in = f;
    flit_in_valid = 1'b1;
    while (!noc_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", 32'(noc_ready), 32'(1));
    if (noc_ready) model_push(f);
    @(negedge clk);
    flit_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit rnd_done = 1'b0;
  int hdr0, elen0;

  initial begin
    rst_n = 1'b0; flit_in = 8'h00; flit_in_valid = 1'b0; out_ready = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_noc_ready", 32'(noc_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_flit", 32'(out_flit), 32'(0));
    chk("rst_err_hdr", 32'(err_hdr), 32'(0));
    chk("rst_err_len", 32'(err_len), 32'(0));
    chk("rst_pkt_done", 32'(pkt_done), 32'(0));
    @(negedge clk);

    // good packet to port 2, latency check on the header
    out_ready = 4'hF;
    send(8'hBE);
    #1 chk("lat_idle", 32'(out_valid), 32'(0));
    send(8'h11);
    #1 chk("lat_fwd", 32'(out_valid), 32'(4'b0100));
    send_pkt('{8'h22, 8'h33, 8'h44, 8'hFF});
    drain();

    // two short packets back to back
    send_pkt('{8'hBC, 8'h5A, 8'hFF, 8'hBD, 8'h01, 8'hFF});
    drain();

    // backpressure: fill the FIFO with everything stalled
    out_ready = 4'b0000;
    send_pkt('{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hBD, 8'h77});
    #1 chk("full_not_ready", 32'(noc_ready), 32'(0));
    flit_in = 8'hFF; flit_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("full_hold", 32'(noc_ready), 32'(0));
    end
    out_ready = 4'b0100;
    @(negedge clk);
    #1 chk("ready_back", 32'(noc_ready), 32'(1));
    send(8'hFF);
    repeat (8) @(negedge clk);
    out_ready = 4'hF;
    drain();

    // bad header prefix
    hdr0 = obs_hdr;
    send_pkt('{8'h03, 8'hAA, 8'hFF});
    drain();
    chk("bad_hdr_pulse", 32'(obs_hdr - hdr0), 32'(1));

    // overlong packet; trailing FF becomes a bad header, flushed by AA,FF
    elen0 = obs_elen;
    hdr0  = obs_hdr;
    send_pkt('{8'hBE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'hAA, 8'hFF});
    drain();
    chk("overlong_err_len", 32'(obs_elen - elen0), 32'(1));
    chk("overlong_err_hdr", 32'(obs_hdr - hdr0), 32'(1));

    // reset in the middle of a packet
    out_ready = 4'b0000;
    send_pkt('{8'hBE, 8'h11});
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_noc_ready", 32'(noc_ready), 32'(1));
    chk("midrst_out_flit", 32'(out_flit), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'hF;
    @(negedge clk);
    send_pkt('{8'hBF, 8'h42, 8'hFF});
    drain();

    // randomized packets with random per-port backpressure
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          logic [7:0] pk[$];
          logic [1:0] dst;
          int nd;
          dst = 2'($urandom_range(0, 3));
          nd  = $urandom_range(1, 4);
          if ($urandom_range(0, 7) == 0)
            pk.push_back({6'($urandom_range(0, 46)), dst});
          else
            pk.push_back({6'b101111, dst});
          for (int i = 0; i < nd; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (i > 0 && d == 8'hFF) d = 8'h00;
            pk.push_back(d);
          end
          pk.push_back(8'hFF);
          foreach (pk[i]) begin
            send(pk[i]);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = 4'($urandom);
        end
      end
    join
    out_ready = 4'hF;
    drain();

    chk("total_err_hdr", 32'(obs_hdr), 32'(exp_hdr));
    chk("total_err_len", 32'(obs_elen), 32'(exp_elen));
    chk("total_pkt_done", 32'(obs_done), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
